// File: rtl/ysyx_22050078_wb_arbiter_pkg.sv
// Shared constants and types for the register-file write-back controller.
package ysyx_22050078_wb_arbiter_pkg;

    localparam int WB_ADDR_WIDTH = 5;
    localparam int WB_DATA_WIDTH = 64;
    localparam int WB_NUM_REGS   = 32;

    localparam logic [WB_DATA_WIDTH-1:0] ysyx_22050078_zero_word = '0;

    // Requester indices: EXU is producer 0, LSU is producer 1.
    typedef enum logic {
        REQ_EXU = 1'b0,
        REQ_LSU = 1'b1
    } req_sel_e;

endpackage

// File: rtl/ysyx_22050078_wb_arbiter_if.sv
// Bus bundle between decode/producers and the write-back controller.
// The slave modport is the controller's view, master is the surrounding pipeline.
interface ysyx_22050078_wb_arbiter_if
    import ysyx_22050078_wb_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int DATA_WIDTH = WB_DATA_WIDTH
);

    logic                  issue_valid;
    logic [ADDR_WIDTH-1:0] issue_rd;
    logic                  issue_ready;
    logic [ADDR_WIDTH-1:0] rs1_addr;
    logic [ADDR_WIDTH-1:0] rs2_addr;
    logic                  rs1_busy;
    logic                  rs2_busy;

    logic                  req0_valid;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_data;
    logic                  req0_ready;

    logic                  req1_valid;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_data;
    logic                  req1_ready;

    logic                  w_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    modport slave (
        input  issue_valid, issue_rd, rs1_addr, rs2_addr,
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output issue_ready, rs1_busy, rs2_busy,
        output req0_ready, req1_ready,
        output w_en, wr_addr, wr_data
    );

    modport master (
        output issue_valid, issue_rd, rs1_addr, rs2_addr,
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  issue_ready, rs1_busy, rs2_busy,
        input  req0_ready, req1_ready,
        input  w_en, wr_addr, wr_data
    );

endinterface

// File: rtl/ysyx_22050078_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set on issue
// and cleared when the register-file write actually happens. x0 never tracks.
module ysyx_22050078_scoreboard
    import ysyx_22050078_wb_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int NUM_REGS   = WB_NUM_REGS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid_i,
    input  logic [ADDR_WIDTH-1:0] issue_rd_i,
    output logic                  issue_ready_o,
    input  logic [ADDR_WIDTH-1:0] rs1_addr_i,
    input  logic [ADDR_WIDTH-1:0] rs2_addr_i,
    output logic                  rs1_busy_o,
    output logic                  rs2_busy_o,
    input  logic                  clr_en_i,
    input  logic [ADDR_WIDTH-1:0] clr_addr_i
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;
    logic                set_en;

    // Lookups: a second writer to a pending rd stalls, sources report busy.
    always_comb begin
        issue_ready_o = !((issue_rd_i != '0) && pending_q[issue_rd_i]);
        rs1_busy_o    = (rs1_addr_i != '0) && pending_q[rs1_addr_i];
        rs2_busy_o    = (rs2_addr_i != '0) && pending_q[rs2_addr_i];
        set_en        = issue_valid_i && issue_ready_o && (issue_rd_i != '0);
    end

    // Next pending vector: clear first so a same-index set takes precedence.
    always_comb begin
        pending_d = pending_q;
        if (clr_en_i && (clr_addr_i != '0)) begin
            pending_d[clr_addr_i] = 1'b0;
        end
        if (set_en) begin
            pending_d[issue_rd_i] = 1'b1;
        end
    end

    // Pending vector register, wiped by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/ysyx_22050078_wb_arbiter.sv
// Write-back controller: arbitrates the single register-file write port between
// the EXU (req0) and LSU (req1), registers the winning write for one cycle, and
// owns the pending-write scoreboard used by decode for hazard detection.
// Build option YSYX_22050078_WB_RR_EN selects round-robin arbitration; without
// it the LSU always wins so a load is never held behind streaming ALU results.
module ysyx_22050078_wb_arbiter
    import ysyx_22050078_wb_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int NUM_REGS   = WB_NUM_REGS
) (
    input  logic                           clk,
    input  logic                           rst_n,
    ysyx_22050078_wb_arbiter_if.slave      bus
);

    logic                  gnt0;
    logic                  gnt1;
    logic                  any_gnt;
    logic [ADDR_WIDTH-1:0] gnt_addr;
    logic [DATA_WIDTH-1:0] gnt_data;

    logic                  w_en_q,    w_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

`ifdef YSYX_22050078_WB_RR_EN
    req_sel_e rr_ptr_q;
    req_sel_e rr_ptr_d;

    // Round-robin grant: pointer breaks ties, and always moves past the winner.
    always_comb begin
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        rr_ptr_d = rr_ptr_q;
        if (bus.req0_valid && bus.req1_valid) begin
            if (rr_ptr_q == REQ_EXU) begin
                gnt0 = 1'b1;
            end else begin
                gnt1 = 1'b1;
            end
        end else begin
            gnt0 = bus.req0_valid;
            gnt1 = bus.req1_valid;
        end
        if (gnt0) begin
            rr_ptr_d = REQ_LSU;
        end else if (gnt1) begin
            rr_ptr_d = REQ_EXU;
        end
    end

    // Preferred-requester pointer, starting at the EXU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= REQ_EXU;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    // Fixed-priority grant: LSU first, EXU only when the LSU is idle.
    always_comb begin
        gnt1 = bus.req1_valid;
        gnt0 = bus.req0_valid && !bus.req1_valid;
    end
`endif

    // Select the winning write; x0 handshakes complete but never write.
    always_comb begin
        any_gnt   = gnt0 || gnt1;
        gnt_addr  = gnt1 ? bus.req1_addr : bus.req0_addr;
        gnt_data  = gnt1 ? bus.req1_data : bus.req0_data;
        w_en_d    = any_gnt && (gnt_addr != '0);
        wr_addr_d = any_gnt ? gnt_addr : wr_addr_q;
        wr_data_d = any_gnt ? gnt_data : wr_data_q;
    end

    // One-cycle output stage towards the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_en_q    <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= ysyx_22050078_zero_word;
        end else begin
            w_en_q    <= w_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.w_en       = w_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;

    ysyx_22050078_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_scoreboard (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_valid_i (bus.issue_valid),
        .issue_rd_i    (bus.issue_rd),
        .issue_ready_o (bus.issue_ready),
        .rs1_addr_i    (bus.rs1_addr),
        .rs2_addr_i    (bus.rs2_addr),
        .rs1_busy_o    (bus.rs1_busy),
        .rs2_busy_o    (bus.rs2_busy),
        .clr_en_i      (w_en_q),
        .clr_addr_i    (wr_addr_q)
    );

endmodule

// File: tb/tb_ysyx_22050078_wb_arbiter.sv
// Bench for the write-back controller: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// register-level model (pending array, last write, preferred requester).
module tb_ysyx_22050078_wb_arbiter;
    import ysyx_22050078_wb_arbiter_pkg::*;

    localparam int AW = 5;
    localparam int DW = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int numCompared   = 0;
    int numMismatched = 0;

    ysyx_22050078_wb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ysyx_22050078_wb_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_REGS   (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts, and reports a mismatch on one line.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        numCompared++;
        if (actual !== expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [AW-1:0] ird,
                                 input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                                 input logic v0, input logic [AW-1:0] a0,
                                 input logic [DW-1:0] d0,
                                 input logic v1, input logic [AW-1:0] a1,
                                 input logic [DW-1:0] d1);
        bus.issue_valid = iv;
        bus.issue_rd    = ird;
        bus.rs1_addr    = r1;
        bus.rs2_addr    = r2;
        bus.req0_valid  = v0;
        bus.req0_addr   = a0;
        bus.req0_data   = d0;
        bus.req1_valid  = v1;
        bus.req1_addr   = a1;
        bus.req1_data   = d1;
    endtask

    task automatic idle(input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        applyStimulus(1'b0, '0, r1, r2, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model state: what the register-file side must look like.
    bit          mPending [32];
    logic        mWEn;
    logic [4:0]  mWAddr;
    logic [63:0] mWData;
    logic        mPrefLsu;
    logic        eIr, eB1, eB2, eG0, eG1;

    // Every falling edge: compare DUT to the model, then advance the model by
    // the effect of the upcoming rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) mPending[i] = 1'b0;
            mWEn     = 1'b0;
            mWAddr   = '0;
            mWData   = '0;
            mPrefLsu = 1'b0;
        end else begin
            eIr = (bus.issue_rd == 0) || !mPending[bus.issue_rd];
            eB1 = (bus.rs1_addr != 0) && mPending[bus.rs1_addr];
            eB2 = (bus.rs2_addr != 0) && mPending[bus.rs2_addr];
`ifdef YSYX_22050078_WB_RR_EN
            if (bus.req0_valid && bus.req1_valid) begin
                eG1 = mPrefLsu;
                eG0 = !mPrefLsu;
            end else begin
                eG0 = bus.req0_valid;
                eG1 = bus.req1_valid;
            end
            if (eG0) mPrefLsu = 1'b1;
            else if (eG1) mPrefLsu = 1'b0;
`else
            eG1 = bus.req1_valid;
            eG0 = bus.req0_valid && !bus.req1_valid;
`endif
            checkOutput("issue_ready", bus.issue_ready, eIr);
            checkOutput("rs1_busy",    bus.rs1_busy,    eB1);
            checkOutput("rs2_busy",    bus.rs2_busy,    eB2);
            checkOutput("req0_ready",  bus.req0_ready,  eG0);
            checkOutput("req1_ready",  bus.req1_ready,  eG1);
            checkOutput("w_en",        bus.w_en,        mWEn);
            checkOutput("wr_addr",     bus.wr_addr,     mWAddr);
            checkOutput("wr_data",     bus.wr_data,     mWData);

            if (mWEn && mWAddr != 0) mPending[mWAddr] = 1'b0;
            if (bus.issue_valid && eIr && bus.issue_rd != 0) mPending[bus.issue_rd] = 1'b1;
            if (eG1) begin
                mWEn   = (bus.req1_addr != 0);
                mWAddr = bus.req1_addr;
                mWData = bus.req1_data;
            end else if (eG0) begin
                mWEn   = (bus.req0_addr != 0);
                mWAddr = bus.req0_addr;
                mWData = bus.req0_data;
            end else begin
                mWEn = 1'b0;
            end
        end
    end

    initial begin
        idle(5'd5, 5'd5);
        bus.issue_rd = 5'd5;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state, no requests.
        #1;
        checkOutput("rst_w_en",        bus.w_en, 0);
        checkOutput("rst_rs1_busy",    bus.rs1_busy, 0);
        checkOutput("rst_rs2_busy",    bus.rs2_busy, 0);
        checkOutput("rst_issue_ready", bus.issue_ready, 1);

        // Issue rd=5, EXU writes it two cycles later.
        tick(); applyStimulus(1'b1, 5'd5, 5'd5, '0, 1'b0, '0, '0, 1'b0, '0, '0);
        #1 checkOutput("iss5_ready", bus.issue_ready, 1);
        tick(); idle(5'd5, '0);
        #1 checkOutput("rs1_busy_after_issue", bus.rs1_busy, 1);
        tick(); applyStimulus(1'b0, '0, 5'd5, '0, 1'b1, 5'd5, 64'hDEAD, 1'b0, '0, '0);
        #1 checkOutput("dead_req0_ready", bus.req0_ready, 1);
        checkOutput("dead_req1_ready", bus.req1_ready, 0);
        tick(); idle(5'd5, '0);
        #1 checkOutput("dead_w_en", bus.w_en, 1);
        checkOutput("dead_wr_addr", bus.wr_addr, 5);
        checkOutput("dead_wr_data", bus.wr_data, 64'hDEAD);
        checkOutput("busy_during_wen", bus.rs1_busy, 1);
        tick();
        #1 checkOutput("dead_w_en_done", bus.w_en, 0);
        checkOutput("busy_after_wen", bus.rs1_busy, 0);
        checkOutput("hold_wr_data", bus.wr_data, 64'hDEAD);

        // WAW stall on rd=7.
        tick(); applyStimulus(1'b1, 5'd7, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
        #1 checkOutput("waw_first_ready", bus.issue_ready, 1);
        tick();
        #1 checkOutput("waw_stall", bus.issue_ready, 0);
        tick(); applyStimulus(1'b1, 5'd7, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7, 64'h77);
        #1 checkOutput("waw_stall_grant", bus.issue_ready, 0);
        checkOutput("waw_req1_ready", bus.req1_ready, 1);
        tick(); applyStimulus(1'b1, 5'd7, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
        #1 checkOutput("waw_w_en", bus.w_en, 1);
        checkOutput("waw_stall_wen", bus.issue_ready, 0);
        tick();
        #1 checkOutput("waw_released", bus.issue_ready, 1);
        tick(); idle('0, 5'd7);
        #1 checkOutput("waw_reset_bit", bus.rs2_busy, 1);
        tick(); applyStimulus(1'b0, '0, '0, 5'd7, 1'b1, 5'd7, 64'h70, 1'b0, '0, '0);
        tick(); idle('0, 5'd7);
        tick();
        #1 checkOutput("waw_cleanup", bus.rs2_busy, 0);

        // Reset asserted during a write cycle.
        tick(); applyStimulus(1'b1, 5'd9, 5'd9, '0, 1'b0, '0, '0, 1'b0, '0, '0);
        tick(); applyStimulus(1'b0, '0, 5'd9, '0, 1'b0, '0, '0, 1'b1, 5'd9, 64'h99);
        #1 checkOutput("mid_busy", bus.rs1_busy, 1);
        tick(); idle(5'd9, '0);
        #1 checkOutput("mid_w_en", bus.w_en, 1);
        rst_n = 1'b0;
        #1 checkOutput("async_w_en", bus.w_en, 0);
        checkOutput("async_wr_data", bus.wr_data, 0);
        checkOutput("async_busy", bus.rs1_busy, 0);
        tick(); tick();
        rst_n = 1'b1;

        // Both producers valid for two cycles.
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 5'd3, 64'h11, 1'b1, 5'd4, 64'h22);
        #1;
`ifdef YSYX_22050078_WB_RR_EN
        checkOutput("both_c1_r0", bus.req0_ready, 1);
        checkOutput("both_c1_r1", bus.req1_ready, 0);
`else
        checkOutput("both_c1_r0", bus.req0_ready, 0);
        checkOutput("both_c1_r1", bus.req1_ready, 1);
`endif
        tick();
        checkOutput("both_c2_r0", bus.req0_ready, 0);
        checkOutput("both_c2_r1", bus.req1_ready, 1);
        checkOutput("both_c2_w_en", bus.w_en, 1);
`ifdef YSYX_22050078_WB_RR_EN
        checkOutput("both_c2_data", bus.wr_data, 64'h11);
        checkOutput("both_c2_addr", bus.wr_addr, 3);
`else
        checkOutput("both_c2_data", bus.wr_data, 64'h22);
        checkOutput("both_c2_addr", bus.wr_addr, 4);
`endif
        idle('0, '0);
        tick();
        checkOutput("both_c3_data", bus.wr_data, 64'h22);
        checkOutput("both_c3_addr", bus.wr_addr, 4);

        // x0 write and x0 issue.
        applyStimulus(1'b1, '0, '0, '0, 1'b1, '0, 64'hFFFF, 1'b0, '0, '0);
        #1 checkOutput("x0_req0_ready", bus.req0_ready, 1);
        checkOutput("x0_issue_ready", bus.issue_ready, 1);
        tick(); idle('0, '0);
        #1 checkOutput("x0_w_en", bus.w_en, 0);
        checkOutput("x0_busy", bus.rs1_busy, 0);

        // Back-to-back LSU writes, addresses 1..8.
        for (int i = 1; i <= 8; i++) begin
            tick();
            applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, '0, 1'b1, 5'(i), 64'h1000 + 64'(i));
            #1 checkOutput("b2b_ready", bus.req1_ready, 1);
            if (i > 1) begin
                checkOutput("b2b_w_en", bus.w_en, 1);
                checkOutput("b2b_addr", bus.wr_addr, 64'(i - 1));
                checkOutput("b2b_data", bus.wr_data, 64'h1000 + 64'(i - 1));
            end
        end
        tick(); idle('0, '0);
        #1 checkOutput("b2b_last_w_en", bus.w_en, 1);
        checkOutput("b2b_last_addr", bus.wr_addr, 8);
        tick();
        #1 checkOutput("b2b_idle_w_en", bus.w_en, 0);

        // Randomized traffic over a small register window to force hazards.
        for (int n = 0; n < 3000; n++) begin
            tick();
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                          {$urandom, $urandom},
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                          {$urandom, $urandom});
        end
        tick(); idle('0, '0);
        repeat (2) @(posedge clk);
        #2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule

// File: doc/ysyx_22050078_wb_arbiter.md
Name: ysyx_22050078_wb_arbiter

Overview:
- Write-back controller for the 32x64 integer register file.
- Shares the single register-file write port between two producers: req0 (EXU, single-cycle ALU results) and req1 (LSU, multi-cycle load data).
- Keeps a 32-entry pending-write scoreboard so the decode stage can detect RAW and WAW hazards.
- Drives the register file's w_en/wr_addr/wr_data from a 1-stage registered output.

Parameters:
- ADDR_WIDTH, 5, register address width.
- DATA_WIDTH, 64, register data width.
- NUM_REGS, 32, scoreboard depth; must equal 2**ADDR_WIDTH.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- issue_valid  input  1  decode issues an instruction that writes rd.
- issue_rd  input  ADDR_WIDTH  destination of the issuing instruction.
- issue_ready  output  1  issue accepted this cycle (combinational).
- rs1_addr  input  ADDR_WIDTH  decode source 1.
- rs2_addr  input  ADDR_WIDTH  decode source 2.
- rs1_busy  output  1  rs1 has a pending write (combinational).
- rs2_busy  output  1  rs2 has a pending write (combinational).
- req0_valid / req1_valid  input  1  producer has a result.
- req0_addr / req1_addr  input  ADDR_WIDTH  result destination.
- req0_data / req1_data  input  DATA_WIDTH  result value.
- req0_ready / req1_ready  output  1  grant; result is consumed this cycle.
- w_en  output  1  to register-file write enable.
- wr_addr  output  ADDR_WIDTH  to register-file write address.
- wr_data  output  DATA_WIDTH  to register-file write data.

Behaviour:
- Reset (async, rst_n low):
  - w_en=0, wr_addr=0, wr_data=0.
  - All scoreboard bits = 0.
  - RR pointer = 0.
  - Reset mid-transfer drops any in-flight write; producers must re-present.
- Arbitration (combinational):
  - At most one of reqN_ready is high per cycle.
  - reqN_ready is high only when reqN_valid is high.
  - The output stage drains every cycle, so a grant is issued whenever any valid is present.
  - Default policy is fixed priority, req1 (LSU) > req0: a load must not be held while the EXU keeps streaming.
- Output stage, 1-cycle latency:
  - If a request is granted in cycle N: w_en=1, wr_addr/wr_data = granted values in cycle N+1.
  - If no grant: w_en=0 in N+1, and wr_addr/wr_data hold their previous values.
- x0 handling:
  - A granted request with addr 0 completes its handshake but produces w_en=0 in N+1.
  - issue_rd=0 never sets a scoreboard bit, and issue_ready=1.
- Scoreboard:
  - Bit set on posedge when issue_valid && issue_ready && issue_rd!=0.
  - Bit cleared on posedge when w_en && wr_addr!=0 (clear takes effect at the end of cycle N+1).
  - Simultaneous set and clear of the same index: set wins. This is unreachable when the WAW rule holds, but must still be implemented.
- issue_ready = !(issue_rd!=0 && pending[issue_rd]) — WAW stall. It is independent of issue_valid.
- rsX_busy = (rsX_addr!=0) && pending[rsX_addr].
  - No forwarding: busy remains 1 during the w_en cycle; the register-file value is readable from the following cycle.
- Writes without a pending bit (e.g. CSR results) are legal and clear nothing extra.

Optional Feature:
- YSYX_22050078_WB_RR_EN
  - Defined: round-robin arbitration. A 1-bit pointer names the preferred requester. When both are valid, the pointer's requester wins, and after any grant the pointer moves to the other requester. With a single valid requester, that requester is granted and the pointer still moves to the non-granted side.
  - Undefined: fixed priority, req1 > req0; the pointer register is not instantiated.

Decomposition:
- Shared package/defines: ADDR/DATA width constants, ysyx_22050078_zero_word, requester index constants REQ_EXU=0 and REQ_LSU=1.
- One natural sub-module: ysyx_22050078_scoreboard (pending bit vector, set/clear logic, busy/ready lookups).
- The arbiter and output register stay in the top module.

Test Plan:
- Reset release, no requests:
  - w_en=0, both busy=0, issue_ready=1.
  - Assert rst_n low mid-write: w_en=0 and scoreboard cleared immediately, without waiting for a clock edge.
- Issue rd=5, then req0 addr=5 data=0xDEAD two cycles later:
  - rs1_addr=5 busy=1 until the cycle after w_en.
  - w_en=1, wr_addr=5, wr_data=0xDEAD exactly one cycle after req0_ready.
- req0 (addr=3, 0x11) and req1 (addr=4, 0x22) valid together for 2 cycles:
  - Fixed priority: req1 granted both cycles, req0 starved.
  - With RR_EN: grants alternate req0, req1 (pointer 0 after reset), giving writes 0x11 then 0x22.
- Issue rd=7 while pending[7]=1:
  - issue_ready=0 until the cycle after the w_en to addr 7.
  - Then issue_ready=1 and the bit is set again.
- req0 addr=0 data=0xFFFF:
  - req0_ready=1, w_en stays 0.
  - issue_rd=0 leaves rs1_addr=0 busy=0.
- Back-to-back req1 every cycle for 8 cycles (addrs 1..8):
  - 8 consecutive w_en pulses with matching addr/data, no bubbles.
